// File: rtl/unpacked_array_lane_fifo.sv
// Multi-lane synchronous FIFO whose entries are unpacked arrays of N lanes, W bits each.
// Show-ahead head output, per-lane write masking, sticky overflow/underflow status.
module unpacked_array_lane_fifo #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [W-1:0]                 d [N],
  input  logic                         lane_mask [N],
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [W-1:0]                 q [N],
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clear_flags
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  logic [W-1:0] mem [DEPTH][N];
  logic [W-1:0] wr_word [N];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status comes only from the registered count, so no input reaches a handshake output combinationally.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign ready_out = !full;
  assign valid_out = !empty;
  assign push      = valid_in && ready_out;
  assign pop       = valid_out && ready_in;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wr_word[i] = lane_mask[i] ? d[i] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < N; i++) begin
        mem[wr_ptr][i] <= wr_word[i];
      end
    end
  end

  // Masking the head while empty keeps stale entries from ever appearing on q.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      q[i] = empty ? '0 : mem[rd_ptr][i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new offending event wins over a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (valid_in && full)      overflow <= 1'b1;
      else if (clear_flags)      overflow <= 1'b0;
      if (ready_in && empty)     underflow <= 1'b1;
      else if (clear_flags)      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unpacked_array_lane_fifo.sv
// Directed bench for unpacked_array_lane_fifo (N=4, W=8, DEPTH=4); lanes packed as {q[0],q[1],q[2],q[3]}.
module tb_unpacked_array_lane_fifo;

  logic       clock;
  logic       reset;
  logic [7:0] d [4];
  logic       lane_mask [4];
  logic       valid_in;
  logic       ready_out;
  logic [7:0] q [4];
  logic       valid_out;
  logic       ready_in;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;
  logic       clear_flags;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [$];
  logic [31:0] word;

  unpacked_array_lane_fifo #(.N(4), .W(8), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .d(d), .lane_mask(lane_mask),
    .valid_in(valid_in), .ready_out(ready_out), .q(q), .valid_out(valid_out),
    .ready_in(ready_in), .count(count), .overflow(overflow),
    .underflow(underflow), .clear_flags(clear_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic [31:0] q_word();
    return {q[0], q[1], q[2], q[3]};
  endfunction

  task automatic set_data(input logic [31:0] w, input logic [3:0] m);
    d[0] = w[31:24]; d[1] = w[23:16]; d[2] = w[15:8]; d[3] = w[7:0];
    lane_mask[0] = m[3]; lane_mask[1] = m[2]; lane_mask[2] = m[1]; lane_mask[3] = m[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    set_data(w, 4'b1111);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; clear_flags = 1'b0;
    set_data(32'h0, 4'b1111);
    step(); step();
    reset = 1'b0;
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_ready_out", 32'(ready_out), 32'd1);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    check("reset_q", q_word(), 32'h0);

    // First push appears on q the next cycle
    push_word(32'h11223344);
    check("first_valid_out", 32'(valid_out), 32'd1);
    check("first_q", q_word(), 32'h11223344);
    check("first_count", 32'(count), 32'd1);

    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    push_word(32'hDDEEFF01);
    check("full_count", 32'(count), 32'd4);
    check("full_ready_out", 32'(ready_out), 32'd0);
    check("full_no_overflow", 32'(overflow), 32'd0);

    push_word(32'h12345678);
    check("overflow_set", 32'(overflow), 32'd1);
    check("overflow_count", 32'(count), 32'd4);
    check("overflow_head", q_word(), 32'h11223344);

    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'd0);

    // Drain in push order
    ready_in = 1'b1;
    check("pop0_q", q_word(), 32'h11223344); step();
    check("pop1_q", q_word(), 32'h55667788); step();
    check("pop2_q", q_word(), 32'h99AABBCC); step();
    check("pop3_q", q_word(), 32'hDDEEFF01); step();
    ready_in = 1'b0;
    check("drained_count", 32'(count), 32'd0);
    check("drained_valid_out", 32'(valid_out), 32'd0);
    check("drained_q", q_word(), 32'h0);
    check("drained_no_underflow", 32'(underflow), 32'd0);

    // Lane masking stores zero in masked lanes
    set_data(32'hAABBCCDD, 4'b1010);
    valid_in = 1'b1; step(); valid_in = 1'b0;
    check("mask_q", q_word(), 32'hAA00CC00);
    check("mask_count", 32'(count), 32'd1);

    // Steady push+pop at count 2 across two pointer wraps
    model.push_back(32'hAA00CC00);
    push_word(32'h01020304);
    model.push_back(32'h01020304);
    valid_in = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      word = 32'h10203040 + 32'(i);
      set_data(word, 4'b1111);
      check($sformatf("stream_q_%0d", i), q_word(), model[0]);
      step();
      void'(model.pop_front());
      model.push_back(word);
      check($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
    end
    valid_in = 1'b0; ready_in = 1'b0;
    check("stream_flags", {30'd0, overflow, underflow}, 32'd0);

    // Full with simultaneous push and pop: pop only, overflow set
    push_word(32'hC0C1C2C3); model.push_back(32'hC0C1C2C3);
    push_word(32'hD0D1D2D3); model.push_back(32'hD0D1D2D3);
    check("refill_count", 32'(count), 32'd4);
    set_data(32'hEEEEEEEE, 4'b1111);
    valid_in = 1'b1; ready_in = 1'b1; step();
    valid_in = 1'b0; ready_in = 1'b0;
    void'(model.pop_front());
    check("fullpp_count", 32'(count), 32'd3);
    check("fullpp_overflow", 32'(overflow), 32'd1);
    check("fullpp_head", q_word(), model[0]);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    check("fullpp_cleared", 32'(overflow), 32'd0);

    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tail_q_%0d", i), q_word(), model[0]);
      step();
      void'(model.pop_front());
    end
    check("tail_count", 32'(count), 32'd0);
    check("tail_no_underflow", 32'(underflow), 32'd0);

    // Pop while empty
    step();
    check("underflow_set", 32'(underflow), 32'd1);
    check("underflow_q", q_word(), 32'h0);
    check("underflow_count", 32'(count), 32'd0);
    clear_flags = 1'b1; step();
    check("underflow_event_beats_clear", 32'(underflow), 32'd1);
    ready_in = 1'b0; step(); clear_flags = 1'b0;
    check("underflow_cleared", 32'(underflow), 32'd0);

    // Push and pop request while empty: push only
    set_data(32'h5A5A0F0F, 4'b1111);
    valid_in = 1'b1; ready_in = 1'b1; step();
    valid_in = 1'b0; ready_in = 1'b0;
    check("empty_pp_count", 32'(count), 32'd1);
    check("empty_pp_q", q_word(), 32'h5A5A0F0F);
    check("empty_pp_underflow", 32'(underflow), 32'd1);

    // Reset with entries stored, overriding a concurrent push
    push_word(32'h01010101);
    push_word(32'h02020202);
    check("prereset_count", 32'(count), 32'd3);
    reset = 1'b1; valid_in = 1'b1; step();
    reset = 1'b0; valid_in = 1'b0;
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_valid_out", 32'(valid_out), 32'd0);
    check("midreset_flags", {30'd0, overflow, underflow}, 32'd0);
    check("midreset_q", q_word(), 32'h0);
    check("midreset_ready_out", 32'(ready_out), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/unpacked_array_lane_fifo.md
Name: unpacked_array_lane_fifo

Overview:
- Multi-lane synchronous FIFO.
- Each entry is an unpacked array of N lanes, each W bits wide (IEEE 1800-2017 7.4.2 sized unpacked arrays used as ports, 23.2.2).
- Generalises the single-bit unpacked-array port pattern in width (W), channel count (N) and storage depth (DEPTH).
- Adds valid/ready handshakes, per-lane write masking and overflow/underflow status.
- Serves as a test vehicle for TMRG triplication of unpacked-array ports and memories.

Parameters:
- N, 4, number of lanes; unpacked dimension of data ports; N >= 1.
- W, 8, bits per lane; W >= 1.
- DEPTH, 4, number of entries; DEPTH >= 2; need not be a power of two.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- d, input, logic [W-1:0] d [N]: write data, one element per lane.
- lane_mask, input, logic lane_mask [N]: per-lane write enable. A lane with mask 0 stores zero.
- valid_in, input, 1: write request.
- ready_out, output, 1: FIFO can accept a write; equals !full.
- q, output, logic [W-1:0] q [N]: head entry, show-ahead.
- valid_out, output, 1: q holds valid data; equals !empty.
- ready_in, input, 1: consumer accepts head.
- count, output, $clog2(DEPTH+1): current number of entries.
- overflow, output, 1: sticky flag; a write was attempted while full.
- underflow, output, 1: sticky flag; a read was attempted while empty.
- clear_flags, input, 1: clears overflow and underflow.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, valid_out=0, ready_out=1, all q lanes 0.
  - Reset has priority over all other inputs.
  - Reset asserted mid-operation discards all stored entries on that edge.
  - Storage array need not be cleared.
- Push:
  - Push occurs when valid_in && ready_out at a rising edge.
  - Entry written at wr_ptr: lane i gets d[i] if lane_mask[i] else 0.
  - wr_ptr advances; it wraps DEPTH-1 -> 0 by explicit compare, not modulo-2^k.
- Pop:
  - Pop occurs when valid_out && ready_in at a rising edge.
  - rd_ptr advances with the same wrap rule.
- Count:
  - push only: count+1. pop only: count-1. Both: count unchanged, and both pointers advance.
- Flags and outputs:
  - full = (count == DEPTH). empty = (count == 0). Both derived from registered count only.
  - q is combinational from storage[rd_ptr] when count > 0, else all lanes 0. q must never show stale data while empty.
- Latency:
  - A word pushed into an empty FIFO appears on q with valid_out=1 in the cycle after the push edge.
  - No combinational path from valid_in to valid_out, or from ready_in to ready_out.
- Boundary cases:
  - Full with valid_in=1 and ready_in=1: the pop is accepted. The push is not accepted, since ready_out=0 that cycle. overflow is set; count becomes DEPTH-1.
  - Full with valid_in=1 and no pop: data dropped, overflow set, state unchanged.
  - Empty with ready_in=1: underflow set, no pointer change. Pop is impossible, so valid_in plus ready_in while empty yields a push only.
  - Flag update priority: reset > set-by-event > clear_flags. An event in the same cycle as clear_flags leaves the flag set.
- Status:
  - overflow and underflow are registered; they assert the cycle after the offending edge.
- Structure: no latches, no asynchronous logic. Unpacked-array ports are kept unpacked; they are not flattened in the port list.

Test Plan (N=4, W=8, DEPTH=4):
- Reset, then push d={11,22,33,44} with mask all 1 -> next cycle valid_out=1, q={11,22,33,44}, count=1.
- Push 4 distinct words with no pops -> count=4, ready_out=0. A 5th valid_in sets overflow=1 and count stays 4. Pop order matches push order.
- Push with mask {1,0,1,0} and d={AA,BB,CC,DD} -> q={AA,00,CC,00}.
- Hold the FIFO at count=2 with continuous push+pop for 10 cycles, crossing the pointer wrap twice -> count stays 2, data in order, no flags set.
- Full plus valid_in=1 and ready_in=1 in the same cycle -> head popped, push dropped, overflow=1, count=3. Then clear_flags -> overflow=0.
- Pop while empty -> underflow=1, q all 0. Assert reset with 3 entries stored -> next cycle count=0, valid_out=0, flags 0, q all 0.
